// File: rtl/lcd_cfah_ctrl_if.sv
// Request channel into the CFAH1602B command sequencer: valid/ready with an rs flag and an 8-bit code.
interface lcd_cfah_ctrl_if;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_rs;
  logic [7:0] i_req_data;

  modport master (output i_req_valid, i_req_rs, i_req_data, input o_req_ready);
  modport slave  (input i_req_valid, i_req_rs, i_req_data, output o_req_ready);
endinterface

// File: rtl/lcd_cfah_ctrl.sv
// CFAH1602B sequencer: power-up wait, 8-bit init ROM, then one itf transaction per request plus execution delay.
// Define LCD_CFAH_CTRL_BUSY_POLL_EN to replace the post-request delay with busy-flag polling.
module lcd_cfah_ctrl #(
  parameter int G_PWRUP_CYCLES    = 2000000,
  parameter int G_CMD_WAIT_CYCLES = 2000,
  parameter int G_CLR_WAIT_CYCLES = 82000,
  parameter int G_POLL_MAX        = 16
) (
  input  logic                clk,
  input  logic                rst,
  lcd_cfah_ctrl_if.slave      req,
  output logic                o_init_done,
  output logic                o_busy,
  output logic                o_err,
  output logic [7:0]          o_itf_wdata,
  output logic                o_itf_rs,
  output logic                o_itf_rw,
  output logic                o_itf_start,
  input  logic                i_itf_done,
  input  logic [7:0]          i_itf_rdata
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXV = max2(max2(G_PWRUP_CYCLES, G_CMD_WAIT_CYCLES), G_CLR_WAIT_CYCLES);
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [3:0] {
    PWRUP_WAIT, INIT_ISSUE, INIT_WAIT_DONE, INIT_DELAY,
    IDLE, REQ_ISSUE, REQ_WAIT_DONE, REQ_DELAY,
    POLL_ISSUE, POLL_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          ready_q;

  assign req.o_req_ready = ready_q;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: return 8'h38;
      3'd2:       return 8'h0C;
      3'd3:       return 8'h01;
      default:    return 8'h06;
    endcase
  endfunction

  // Clear/home instructions need the long execution time; data writes never do.
  function automatic logic [CW-1:0] wait_m1(input logic rs, input logic [7:0] d);
    if (!rs && d >= 8'h01 && d <= 8'h03) return CW'(G_CLR_WAIT_CYCLES - 1);
    return CW'(G_CMD_WAIT_CYCLES - 1);
  endfunction

`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
  localparam int PW = $clog2(G_POLL_MAX + 1);
  logic [PW-1:0] poll_cnt;
  logic          unused_rdata;
  assign unused_rdata = ^i_itf_rdata[6:0];
`else
  logic          unused_rdata;
  assign unused_rdata = ^i_itf_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PWRUP_WAIT;
      cnt         <= CW'(G_PWRUP_CYCLES);
      idx         <= 3'd0;
      ready_q     <= 1'b0;
      o_init_done <= 1'b0;
      o_busy      <= 1'b1;
      o_err       <= 1'b0;
      o_itf_wdata <= 8'h00;
      o_itf_rs    <= 1'b0;
      o_itf_rw    <= 1'b0;
      o_itf_start <= 1'b0;
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
      poll_cnt    <= '0;
`endif
    end else begin
      o_itf_start <= 1'b0;
      case (state)
        PWRUP_WAIT:
          if (cnt == '0) begin
            state       <= INIT_ISSUE;
            idx         <= 3'd0;
            o_itf_wdata <= init_rom(3'd0);
            o_itf_rs    <= 1'b0;
            o_itf_rw    <= 1'b0;
            o_itf_start <= 1'b1;
          end else cnt <= cnt - 1'b1;
        INIT_ISSUE: state <= INIT_WAIT_DONE;
        INIT_WAIT_DONE:
          if (i_itf_done) begin
            state <= INIT_DELAY;
            cnt   <= wait_m1(o_itf_rs, o_itf_wdata);
          end
        INIT_DELAY:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (idx == 3'd4) begin
            state       <= IDLE;
            o_init_done <= 1'b1;
            ready_q     <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            state       <= INIT_ISSUE;
            idx         <= idx + 3'd1;
            o_itf_wdata <= init_rom(idx + 3'd1);
            o_itf_start <= 1'b1;
          end
        IDLE:
          if (req.i_req_valid) begin
            state       <= REQ_ISSUE;
            ready_q     <= 1'b0;
            o_busy      <= 1'b1;
            o_itf_wdata <= req.i_req_data;
            o_itf_rs    <= req.i_req_rs;
            o_itf_rw    <= 1'b0;
            o_itf_start <= 1'b1;
          end
        REQ_ISSUE: state <= REQ_WAIT_DONE;
        REQ_WAIT_DONE:
          if (i_itf_done) begin
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
            state       <= POLL_ISSUE;
            poll_cnt    <= '0;
            o_itf_wdata <= 8'h00;
            o_itf_rs    <= 1'b0;
            o_itf_rw    <= 1'b1;
            o_itf_start <= 1'b1;
`else
            state <= REQ_DELAY;
            cnt   <= wait_m1(o_itf_rs, o_itf_wdata);
`endif
          end
        REQ_DELAY:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            o_busy  <= 1'b0;
          end
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
        POLL_ISSUE: state <= POLL_WAIT;
        POLL_WAIT:
          if (i_itf_done) begin
            if (!i_itf_rdata[7] || poll_cnt == PW'(G_POLL_MAX - 1)) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              o_busy  <= 1'b0;
              if (i_itf_rdata[7]) o_err <= 1'b1;
            end else begin
              state       <= POLL_ISSUE;
              poll_cnt    <= poll_cnt + 1'b1;
              o_itf_start <= 1'b1;
            end
          end
`endif
        default: state <= PWRUP_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cfah_ctrl.sv
// Directed bench for lcd_cfah_ctrl with a 3-cycle-latency itf responder and a start-pulse log.
module tb_lcd_cfah_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done, busy, err, itf_rs, itf_rw, itf_start, spur;
  logic [7:0] itf_wdata, rdata;
  logic       mdl_done = 1'b0;
  logic       mrw = 1'b0;
  logic [2:0] mcnt = 3'd0;
  logic [7:0] rd_q[$];
  logic [7:0] rd_dflt;
  int         cyc = 0;
  int         st_cyc[$];
  logic [9:0] st_dat[$];
  int         n_chk = 0, n_fail = 0;

  lcd_cfah_ctrl_if rq();

  lcd_cfah_ctrl #(
    .G_PWRUP_CYCLES(100), .G_CMD_WAIT_CYCLES(10), .G_CLR_WAIT_CYCLES(50), .G_POLL_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .req(rq), .o_init_done(init_done), .o_busy(busy), .o_err(err),
    .o_itf_wdata(itf_wdata), .o_itf_rs(itf_rs), .o_itf_rw(itf_rw), .o_itf_start(itf_start),
    .i_itf_done(mdl_done | spur), .i_itf_rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // itf responder: one-cycle done 3 cycles after the start pulse is sampled
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (itf_start) begin
      mcnt <= 3'd3;
      mrw  <= itf_rw;
    end else if (mcnt != 3'd0) begin
      mcnt <= mcnt - 3'd1;
      if (mcnt == 3'd1) begin
        mdl_done <= 1'b1;
        if (!mrw) rdata <= 8'h00;
        else if (rd_q.size() > 0) rdata <= rd_q.pop_front();
        else rdata <= rd_dflt;
      end
    end
  end

  always @(negedge clk)
    if (itf_start) begin
      st_cyc.push_back(cyc);
      st_dat.push_back({itf_rw, itf_rs, itf_wdata});
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (rq.o_req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (rq.o_req_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_init(output int c);
    int n = 0;
    while (init_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (init_done !== 1'b1) chk("init_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int acc, output int low);
    wait_ready();
    rq.i_req_valid = 1'b1; rq.i_req_rs = rs; rq.i_req_data = d; acc = cyc;
    @(posedge clk); #1 rq.i_req_valid = 1'b0;
    low = 0;
    do begin
      @(negedge clk);
      if (rq.o_req_ready !== 1'b1) low++;
    end while (rq.o_req_ready !== 1'b1 && low < 500);
  endtask

  // {ready, init_done, busy, err, rs, rw, start, wdata}
  function automatic logic [14:0] outs();
    return {rq.o_req_ready, init_done, busy, err, itf_rs, itf_rw, itf_start, itf_wdata};
  endfunction

  localparam logic [14:0] RST_OUTS = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
  logic [7:0] rom[5]   = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         gap_e[4] = '{15, 15, 15, 55};
  logic       t_rs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] t_dat[6] = '{8'h41, 8'h01, 8'h80, 8'h02, 8'h03, 8'h04};
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
  int         t_low[6] = '{10, 10, 10, 10, 10, 10};
  localparam int B2B_GAP = 11;
`else
  int         t_low[6] = '{15, 55, 15, 15, 55, 15};
  localparam int B2B_GAP = 16;
`endif

  initial begin
    int rel, idc, b, acc, low, nrd;
    spur = 1'b0; rd_dflt = 8'h00; rdata = 8'h00;
    rq.i_req_valid = 1'b0; rq.i_req_rs = 1'b0; rq.i_req_data = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk); chk("reset_outs", outs(), RST_OUTS);
    @(posedge clk); #1 rst = 1'b0; rel = cyc;

    // request held during power-up and init must never be taken
    rq.i_req_valid = 1'b1; rq.i_req_rs = 1'b1; rq.i_req_data = 8'h55;
    wait_init(idc);
    rq.i_req_valid = 1'b0;
    chk("init_ready", {rq.o_req_ready, busy}, 2'b10);
    chk("init_nstarts", st_cyc.size(), 5);
    if (st_cyc.size() >= 5) begin
      chk("pwrup_len", st_cyc[0] - rel, 101);
      for (int i = 0; i < 5; i++) chk($sformatf("init_cmd%0d", i), st_dat[i], {2'b00, rom[i]});
      for (int i = 0; i < 4; i++) chk($sformatf("init_gap%0d", i), st_cyc[i+1] - st_cyc[i], gap_e[i]);
      chk("init_done_lat", idc - st_cyc[4], 15);
    end
    @(negedge clk);
    chk("no_early_accept", st_cyc.size(), 5);

    for (int i = 0; i < 6; i++) begin
      b = st_cyc.size();
      send(t_rs[i], t_dat[i], acc, low);
      chk($sformatf("req%0d_low", i), low, t_low[i]);
      chk($sformatf("req%0d_lat", i), st_cyc[b] - acc, 1);
      chk($sformatf("req%0d_dat", i), st_dat[b], {1'b0, t_rs[i], t_dat[i]});
    end

    // valid held across two requests
    b = st_cyc.size();
    rq.i_req_valid = 1'b1; rq.i_req_rs = 1'b1; rq.i_req_data = 8'h48;
    @(posedge clk); #1 rq.i_req_data = 8'h49;
    @(negedge clk); wait_ready();
    @(posedge clk); #1 rq.i_req_valid = 1'b0;
    @(negedge clk); wait_ready();
    repeat (20) @(negedge clk);
    chk("b2b_count", st_cyc.size() - b, 2);
    if (st_cyc.size() - b >= 2) begin
      chk("b2b_first", st_dat[b], {2'b01, 8'h48});
      chk("b2b_second", st_dat[b+1], {2'b01, 8'h49});
      chk("b2b_gap", st_cyc[b+1] - st_cyc[b], B2B_GAP);
    end

    // stray done while idle
    b = st_cyc.size();
    spur = 1'b1; @(negedge clk); spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_idle", {rq.o_req_ready, busy, 1'(st_cyc.size() - b)}, 3'b100);

`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
    rd_q.push_back(8'h80); rd_q.push_back(8'h80); rd_q.push_back(8'h00);
    b = st_cyc.size();
    send(1'b1, 8'h41, acc, low);
    nrd = 0;
    for (int i = b; i < st_cyc.size(); i++) if (st_dat[i] == 10'h200) nrd++;
    chk("poll3_reads", nrd, 3);
    chk("poll3_err", {err, rq.o_req_ready}, 2'b01);
    rd_dflt = 8'h80;
    b = st_cyc.size();
    send(1'b1, 8'h42, acc, low);
    nrd = 0;
    for (int i = b; i < st_cyc.size(); i++) if (st_dat[i] == 10'h200) nrd++;
    chk("poll_stuck_reads", nrd, 4);
    chk("poll_stuck_err", {err, rq.o_req_ready}, 2'b11);
    rd_dflt = 8'h00;
`else
    nrd = 0;
    for (int i = 0; i < st_dat.size(); i++) if (st_dat[i][9]) nrd++;
    chk("no_reads_no_err", {nrd[3:0], err}, 5'b0);
`endif

    // reset while waiting for done
    b = st_cyc.size();
    wait_ready();
    rq.i_req_valid = 1'b1; rq.i_req_rs = 1'b1; rq.i_req_data = 8'h41;
    @(posedge clk); #1 rq.i_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 chk("midflight_reset", outs(), RST_OUTS);
    rst = 1'b0; rel = cyc;
    wait_init(idc);
    chk("reinit_nstarts", st_cyc.size() - b, 6);
    if (st_cyc.size() - b >= 6) begin
      chk("reinit_pwrup", st_cyc[b+1] - rel, 101);
      chk("reinit_first", st_dat[b+1], {2'b00, 8'h38});
      chk("reinit_last", st_dat[b+5], {2'b00, 8'h06});
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
